// File: rtl/ps2_event_receiver.sv
// ps2_event_receiver: filtered PS/2 frame receiver with set-2 make/break decoding and an event FIFO
module ps2_event_receiver #(
    parameter int FIFO_DEPTH      = 8,
    parameter int FILTER_LEN      = 4,
    parameter int TIMEOUT_CYCLES  = 5000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          psClk,
    input  logic                          psData,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [7:0]                    err_count,
    output logic [7:0]                    keycode,
    output logic                          press
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // index 0 is the clock line, index 1 the data line
    logic [1:0]    s1_q, s2_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;
    logic          fall, din;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    sh_q, sh_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          strobe_q, strobe_d, err_q, err_d;
    logic [7:0]    byte_q, byte_d;

    logic          ext_pend_q, brk_pend_q, held_ext_q, press_q;
    logic [7:0]    keycode_q, err_cnt_q;
    logic          is_disc, ev_en, same_key, drop, push;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          ovf_q, full, pop, wr;
    logic [9:0]    head;

    // two-flop synchroniser followed by a run-length glitch filter per line
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_q       <= 2'b11;
            s2_q       <= 2'b11;
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            s1_q       <= {psData, psClk};
            s2_q       <= s1_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= s2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];
    assign din  = filt_q[1];

    // frame FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            wd_q      <= '0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            wd_q      <= wd_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
            byte_q    <= byte_d;
        end
    end

    // frame FSM: start detect, bit shifting, parity/stop check and watchdog
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        wd_d      = wd_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
        byte_d    = byte_q;
        case (state_q)
            IDLE: begin
                if (fall && !din) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    wd_d      = '0;
                end
            end
            SHIFT: begin
                if (fall) begin
                    wd_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        strobe_d = (^sh_q) & din;
                        err_d    = ~((^sh_q) & din);
                        byte_d   = sh_q[7:0];
                        state_d  = IDLE;
                    end else begin
                        sh_d      = {din, sh_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign is_disc  = byte_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    assign ev_en    = strobe_q && !(byte_q inside {8'hE0, 8'hF0, 8'hE1}) && !is_disc;
    assign same_key = {held_ext_q, keycode_q} == {ext_pend_q, byte_q};
    assign drop     = SUPPRESS_REPEAT && !brk_pend_q && press_q && same_key;
    assign push     = ev_en && !drop;

    // prefix tracking and held-key state for the legacy keycode/press outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            held_ext_q <= 1'b0;
            press_q    <= 1'b0;
            keycode_q  <= '0;
        end else if (strobe_q) begin
            if (byte_q == 8'hE0) begin
                ext_pend_q <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_pend_q <= 1'b1;
            end else if (byte_q != 8'hE1) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end
            if (ev_en && !brk_pend_q && !drop) begin
                keycode_q  <= byte_q;
                held_ext_q <= ext_pend_q;
                press_q    <= 1'b1;
            end
            if (ev_en && brk_pend_q && same_key) press_q <= 1'b0;
        end
    end

    assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign pop  = ev_valid && ev_ready;
    assign wr   = push && (!full || pop);

    // FIFO storage; contents need no reset because the level gates visibility
    always_ff @(posedge Clk) begin
        if (wr) mem[wptr_q] <= {ext_pend_q, brk_pend_q, byte_q};
    end

    // FIFO pointers, level and sticky overflow
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    // saturating frame error counter
    always_ff @(posedge Clk) begin
        if (Reset) err_cnt_q <= '0;
        else if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
    end

    assign head       = mem[rptr_q];
    assign ev_valid   = cnt_q != '0;
    assign ev_code    = ev_valid ? head[7:0] : 8'h00;
    assign ev_break   = ev_valid ? head[8] : 1'b0;
    assign ev_ext     = ev_valid ? head[9] : 1'b0;
    assign fifo_level = cnt_q;
    assign overflow   = ovf_q;
    assign frame_err  = err_q;
    assign err_count  = err_cnt_q;
    assign keycode    = keycode_q;
    assign press      = press_q;
endmodule

// File: tb/tb_ps2_event_receiver.sv
// tb_ps2_event_receiver: directed and random PS/2 frames checked against a behavioural event model
module tb_ps2_event_receiver;
    localparam int DEPTH = 8;

    logic       Clk = 1'b0, Reset = 1'b1, psClk = 1'b1, psData = 1'b1, ev_ready = 1'b0;
    logic       ev_valid, ev_ext, ev_break, overflow, frame_err, press;
    logic [7:0] ev_code, err_count, keycode;
    logic [3:0] fifo_level;
    logic       r_valid, r_ext, r_break, r_ovf, r_err, r_press;
    logic [7:0] r_code, r_err_count, r_keycode;
    logic [3:0] r_level;

    int n_chk = 0, n_fail = 0, err_pulses = 0, rep_pops = 0;
    int lat, base_lat;
    logic [7:0] kc_at, code_at;
    logic pr_at;

    logic [9:0] mq[$];
    logic m_ext = 0, m_brk = 0, m_held_ext = 0, m_press = 0, m_ovf = 0;
    logic [7:0] m_kc = 0;

    always #5 Clk = ~Clk;

    ps2_event_receiver #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYCLES(200), .SUPPRESS_REPEAT(1'b1)) u_dut (
        .Clk(Clk), .Reset(Reset), .psClk(psClk), .psData(psData),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err), .err_count(err_count),
        .keycode(keycode), .press(press));

    ps2_event_receiver #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYCLES(200), .SUPPRESS_REPEAT(1'b0)) u_rep (
        .Clk(Clk), .Reset(Reset), .psClk(psClk), .psData(psData),
        .ev_valid(r_valid), .ev_ready(1'b1), .ev_code(r_code), .ev_ext(r_ext), .ev_break(r_break),
        .fifo_level(r_level), .overflow(r_ovf), .frame_err(r_err), .err_count(r_err_count),
        .keycode(r_keycode), .press(r_press));

    // count frame error pulses and events drained from the repeat-enabled instance
    always @(negedge Clk) begin
        if (frame_err === 1'b1) err_pulses++;
        if (r_valid === 1'b1) rep_pops++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par = 0, input logic stop = 1'b1,
                              input int nbits = 11, input bit glitch = 0, input int pop_at = 0);
        logic [10:0] f;
        f = {stop, ~(^b) ^ flip_par, b, 1'b0};
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            psData = f[i];
            for (int c = 1; c <= 20; c++) begin
                @(negedge Clk);
                if (glitch && c == 5) psClk = 1'b0;
                if (glitch && c == 7) psClk = 1'b1;
            end
            psClk = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge Clk);
                if (i == 10) begin
                    if (lat < 0 && ev_valid === 1'b1) begin
                        lat = c; kc_at = keycode; pr_at = press; code_at = ev_code;
                    end
                    if (pop_at > 0 && c == pop_at - 1) ev_ready = 1'b1;
                    else if (pop_at > 0 && c == pop_at) ev_ready = 1'b0;
                end
            end
            psClk = 1'b1;
            cyc(20);
        end
        psData = 1'b1;
        cyc(20);
    endtask

    task automatic model_push(input logic [9:0] ev);
        if (mq.size() < DEPTH) mq.push_back(ev);
        else m_ovf = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE1) begin end
        else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
            m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            if (m_brk) begin
                if (m_held_ext == m_ext && m_kc == b) m_press = 1'b0;
                model_push({m_ext, 1'b1, b});
            end else if (!(m_press && m_held_ext == m_ext && m_kc == b)) begin
                m_kc = b; m_held_ext = m_ext; m_press = 1'b1;
                model_push({m_ext, 1'b0, b});
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b);
        model_byte(b);
    endtask

    task automatic check_state(input string tag);
        chk({tag, " keycode"}, keycode, m_kc);
        chk({tag, " press"}, press, m_press);
        chk({tag, " overflow"}, overflow, m_ovf);
    endtask

    task automatic drain(input string tag);
        chk({tag, " level"}, fifo_level, mq.size());
        ev_ready = 1'b1;
        while (mq.size() > 0) begin
            chk({tag, " valid"}, ev_valid, 1);
            chk({tag, " event"}, {ev_ext, ev_break, ev_code}, mq[0]);
            @(negedge Clk);
            void'(mq.pop_front());
        end
        ev_ready = 1'b0;
        chk({tag, " empty"}, ev_valid, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pool [11] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'h1C, 8'h29, 8'h75, 8'h5A, 8'h6B};
        logic [7:0] fill [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        int e0, r0, el;

        cyc(5);
        chk("rst ev_valid", ev_valid, 0);
        chk("rst level", fifo_level, 0);
        chk("rst overflow", overflow, 0);
        chk("rst frame_err", frame_err, 0);
        chk("rst err_count", err_count, 0);
        chk("rst keycode", keycode, 0);
        chk("rst press", press, 0);
        Reset = 1'b0;
        cyc(10);

        key(8'h1C);
        chk("make latency", (lat >= 6 && lat <= 10), 1);
        base_lat = lat;
        chk("make keycode at valid", kc_at, 8'h1C);
        chk("make press at valid", pr_at, 1);
        check_state("make");
        drain("make");

        ev_ready = 1'b1;
        key(8'h6B);
        ev_ready = 1'b0;
        void'(mq.pop_front());
        chk("no fall-through latency", lat, base_lat);
        chk("no fall-through code", code_at, 8'h6B);
        drain("ready held");

        key(8'hE0); key(8'h75);
        check_state("ext make");
        key(8'hF0); key(8'h1C);
        check_state("other break");
        key(8'hE0); key(8'hF0); key(8'h75);
        check_state("ext break");
        drain("ext");

        e0 = err_pulses;
        send_frame(8'h1C, 1);
        chk("parity err pulse", err_pulses - e0, 1);
        chk("parity err_count", err_count, 1);
        chk("parity no event", fifo_level, 0);
        send_frame(8'h1C, 0, 1'b0);
        chk("stop err_count", err_count, 2);
        chk("stop no event", fifo_level, 0);
        e0 = err_pulses;
        send_frame(8'h3B, 0, 1'b1, 5);
        el = 0;
        while (err_pulses == e0 && el < 400) begin
            @(negedge Clk);
            el++;
        end
        chk("timeout window", (el >= 110 && el <= 140), 1);
        cyc(5);
        chk("timeout single pulse", err_pulses - e0, 1);
        chk("timeout err_count", err_count, 3);
        key(8'h29);
        check_state("after timeout");
        drain("after timeout");

        key(8'hF0); key(8'h29);
        drain("release");
        r0 = rep_pops;
        key(8'h1C); key(8'h1C); key(8'h1C);
        check_state("repeat");
        drain("repeat");
        chk("repeat unsuppressed events", rep_pops - r0, 3);
        send_frame(8'h5A, 0, 1'b1, 11, 1);
        model_byte(8'h5A);
        check_state("glitch");
        drain("glitch");

        for (int i = 0; i < 9; i++) key(fill[i]);
        chk("full level", fifo_level, DEPTH);
        chk("full head", {ev_ext, ev_break, ev_code}, mq[0]);
        check_state("full");
        send_frame(8'h4B, 0, 1'b1, 11, 0, base_lat);
        void'(mq.pop_front());
        model_byte(8'h4B);
        chk("push+pop at full level", fifo_level, DEPTH);
        drain("full order");

        send_frame(8'h3B, 0, 1'b1, 4);
        Reset = 1'b1;
        cyc(3);
        Reset = 1'b0;
        mq.delete();
        m_ext = 0; m_brk = 0; m_held_ext = 0; m_press = 0; m_ovf = 0; m_kc = 0;
        chk("midrst ev_valid", ev_valid, 0);
        chk("midrst level", fifo_level, 0);
        chk("midrst err_count", err_count, 0);
        check_state("midrst");
        cyc(300);
        chk("midrst no late timeout", err_count, 0);
        key(8'h1C); key(8'hAA); key(8'hFA);
        check_state("post reset");
        drain("post reset");

        for (int n = 0; n < 24; n++) begin
            key(pool[$urandom_range(0, 10)]);
            chk("rand level", fifo_level, mq.size());
            check_state("rand");
            if (n % 4 == 3) drain("rand");
        end
        drain("rand final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
